jtbubl_snd_out: RTL
===================

Name: jtbubl_snd_out

Overview:
- Audio output stage directly downstream of the Bubble Bobble/Tokio sound subsystem.
- Consumes the mixed signed 16-bit sound word and its sample strobe.
- Applies a first-order IIR low-pass, a master gain and a click-free mute ramp, with saturation.
- Drives both a registered PCM output for the frame's audio path and a 1-bit delta-sigma DAC pin.

Parameters:
- LPF_SH, 2: IIR shift; 0 = filter bypass (y=x).
- RAMP_STEP, 8: ramp increment/decrement per accepted sample (1..256).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  1 = audio on (ramp up), 0 = mute (ramp down)
- gain  in  8  unsigned master gain, 0x20 = unity (x1.0), 0xFF = x7.97
- snd  in  16  signed mixed sound from sound subsystem
- sample  in  1  sample strobe from sound subsystem (level, rising edge = new sample)
- snd_out  out  16  signed filtered/scaled sound
- sample_out  out  1  one-clk pulse, snd_out updated
- peak  out  1  high with sample_out when saturation occurred on that sample
- dac  out  1  1-bit delta-sigma output

Behaviour:
- Reset (async, rst=1): all regs 0; snd_out=0, sample_out=0, peak=0, dac=0, state=MUTE, ramp=0, sample_l=0.
- Edge detect: sample_l<=sample every clk; accept = sample & ~sample_l. No cen: block runs every clk.
- Pipeline, accept seen at clk edge N:
  - N: IIR update, plus state/ramp update (below).
  - N+1: gain/ramp multiply.
  - N+2: saturate, register snd_out, sample_out=1, peak valid.
  - sample_out=0 at N+3. Latency 3 clks; snd_out held between samples.
- Accept while pipeline busy (spacing <3 clks): each accept enters independently. No drop while spacing >=1 clk; pipeline is fully registered.
- IIR:
  - acc has 16+LPF_SH bits, signed.
  - acc <= acc + snd - (acc>>>LPF_SH); y = acc>>>LPF_SH (arithmetic).
  - Steady input x gives y -> x exactly.
  - LPF_SH=0: y=snd registered.
- Gain stage:
  - p1 = y * {1'b0,gain} (signed 25b); p2 = (p1>>>5) * {ramp} (ramp 9b unsigned 0..256); r = p2>>>8.
  - Intermediate widths must not overflow for any inputs.
- Saturation: r > 32767 -> 32767, r < -32768 -> -32768, peak=1; else snd_out=r[15:0], peak=0.
- Mute FSM, evaluated only on accept, using en at that clk:
  - MUTE: ramp=0; en=1 -> UP.
  - UP: ramp <= min(ramp+RAMP_STEP,256); reaching 256 -> ON; en=0 -> DOWN (no step that sample).
  - ON: ramp=256; en=0 -> DOWN.
  - DOWN: ramp <= max(ramp-RAMP_STEP,0); reaching 0 -> MUTE; en=1 -> UP (no step that sample).
  - Ramp value used in the multiply is the value after that accept's update.
- en changes without sample strobes have no effect until the next accept.
- DAC:
  - Every clk: u = snd_out ^ 16'h8000 (offset binary); s = {1'b0,acc_d[15:0]} + u; acc_d <= s[15:0]; dac <= s[16].
  - Mean duty = u/65536.
- Reset mid-operation: pipeline contents discarded, no sample_out pulse generated from in-flight data; after release the first pulse requires a fresh rising edge of sample (sample already high at release is not an edge until it falls and rises).

Test Plan:
- Reset, then hold snd=0 -> snd_out=0, sample_out never pulses without strobe; dac alternates 0,1,0,1 starting with 0 on first clk after reset release.
- en=1, gain=0x20, LPF_SH=0, snd=1000, strobe every 16 clks -> ramp 8,16..256 over 32 samples. Output rises 31,62..1000 (r=1000*ramp/256, floored toward -inf). sample_out exactly 3 clks after each strobe rise.
- From ON, LPF_SH=2, step snd 0->4000, gain=0x20 -> outputs 1000,1750,2312,2734.. converging to 4000 with no overshoot.
- ON, gain=0xFF, snd=+20000 steady -> snd_out=32767, peak=1. snd=-20000 -> -32768, peak=1. gain=0x20 -> peak=0.
- ON, drop en for 10 samples then raise -> ramp 248..176 then back up from 176+8. No jump larger than one RAMP_STEP in ramp.
- Assert rst for 1 clk 1 cycle after a strobe -> no sample_out pulse, snd_out=0, state MUTE. snd_out=+32767 held -> dac duty 65535/65536 over 65536 clks.

Source files
------------

// File: rtl/jtbubl_snd_out.sv
// Audio output stage for the Bubble Bobble / Tokio sound subsystem.
// First-order IIR low-pass, master gain, click-free mute ramp with saturation,
// registered PCM output and a first-order 1-bit delta-sigma DAC.
`timescale 1ns/1ps
module jtbubl_snd_out #(
    parameter int unsigned LPF_SH    = 2,
    parameter int unsigned RAMP_STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  gain,
    input  logic [15:0] snd,
    input  logic        sample,
    output logic [15:0] snd_out,
    output logic        sample_out,
    output logic        peak,
    output logic        dac
);

    localparam int unsigned AW       = 16 + LPF_SH;
    localparam logic [8:0]  RampFull = 9'd256;
    localparam logic [9:0]  Step     = 10'(RAMP_STEP);

    typedef enum logic [1:0] {StMute, StUp, StOn, StDown} state_e;

    // ------------------------------------------------------------------
    // Sample strobe edge detect. The arm flag makes a strobe that is already
    // high when reset is released wait for a full low/high cycle.
    // ------------------------------------------------------------------
    logic sample_l_q;
    logic armed_q;
    logic accept;

    assign accept = sample & ~sample_l_q & armed_q;

    // strobe history and post-reset arming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_l_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sample_l_q <= sample;
            armed_q    <= armed_q | ~sample;
        end
    end

    // ------------------------------------------------------------------
    // IIR low-pass: acc holds y scaled by 2^LPF_SH, so a steady input settles
    // to y == x exactly. Modulo-AW arithmetic is safe: acc always fits.
    // ------------------------------------------------------------------
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] snd_ext;
    logic signed [15:0]   y;

    assign snd_ext = AW'($signed(snd));
    assign acc_d   = acc_q + snd_ext - (acc_q >>> LPF_SH);
    assign y       = 16'(acc_q >>> LPF_SH);

    // filter state, advanced once per accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Mute ramp FSM, stepped only on accepted samples
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [8:0] ramp_q, ramp_d;
    logic [9:0] ramp_up;
    logic [8:0] ramp_dn;
    logic       up_full;
    logic       dn_empty;

    assign ramp_up  = {1'b0, ramp_q} + Step;
    assign up_full  = ramp_up >= 10'(RampFull);
    assign dn_empty = {1'b0, ramp_q} <= Step;
    assign ramp_dn  = ramp_q - Step[8:0];

    // next ramp/state; a direction reversal holds the ramp for that sample
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        if (accept) begin
            case (state_q)
                StMute: begin
                    ramp_d = '0;
                    if (en) begin
                        ramp_d  = up_full ? RampFull : ramp_up[8:0];
                        state_d = up_full ? StOn : StUp;
                    end
                end
                StUp: begin
                    if (!en) begin
                        state_d = StDown;
                    end else begin
                        ramp_d  = up_full ? RampFull : ramp_up[8:0];
                        state_d = up_full ? StOn : StUp;
                    end
                end
                StOn: begin
                    ramp_d = RampFull;
                    if (!en) begin
                        ramp_d  = dn_empty ? 9'd0 : ramp_dn;
                        state_d = dn_empty ? StMute : StDown;
                    end
                end
                StDown: begin
                    if (en) begin
                        state_d = StUp;
                    end else begin
                        ramp_d  = dn_empty ? 9'd0 : ramp_dn;
                        state_d = dn_empty ? StMute : StDown;
                    end
                end
                default: begin
                    state_d = StMute;
                    ramp_d  = '0;
                end
            endcase
        end
    end

    // ramp FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StMute;
            ramp_q  <= '0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
        end
    end

    // ------------------------------------------------------------------
    // Gain and ramp multiply (stage 1), saturation and output (stage 2).
    // Widths: |y*gain| < 2^23, |(p1>>>5)*ramp| < 2^27, so nothing wraps.
    // ------------------------------------------------------------------
    logic               v1_q, v2_q;
    logic signed [24:0] p1;
    logic signed [19:0] p1_sh;
    logic signed [29:0] p2_d, p2_q;
    logic signed [21:0] r;
    logic               sat_hi, sat_lo;

    // gain and ramp products for the sample in stage 1
    always_comb begin
        p1    = 25'(y) * 25'($signed({1'b0, gain}));
        p1_sh = 20'(p1 >>> 5);
        p2_d  = 30'(p1_sh) * 30'($signed({1'b0, ramp_q}));
    end

    assign r      = 22'(p2_q >>> 8);
    assign sat_hi = r > 22'sd32767;
    assign sat_lo = r < -22'sd32768;

    // pipeline valids, product register and saturated output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            p2_q       <= '0;
            snd_out    <= '0;
            sample_out <= 1'b0;
            peak       <= 1'b0;
        end else begin
            v1_q       <= accept;
            v2_q       <= v1_q;
            sample_out <= v2_q;
            peak       <= v2_q & (sat_hi | sat_lo);
            if (v1_q) begin
                p2_q <= p2_d;
            end
            if (v2_q) begin
                snd_out <= sat_hi ? 16'h7fff : (sat_lo ? 16'h8000 : r[15:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // First-order delta-sigma DAC on the offset-binary output word
    // ------------------------------------------------------------------
    logic [15:0] dac_acc_q;
    logic [15:0] dac_u;
    logic [16:0] dac_sum;

    assign dac_u   = {~snd_out[15], snd_out[14:0]};
    assign dac_sum = {1'b0, dac_acc_q} + {1'b0, dac_u};

    // DAC accumulator; the carry out is the pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_acc_q <= '0;
            dac       <= 1'b0;
        end else begin
            dac_acc_q <= dac_sum[15:0];
            dac       <= dac_sum[16];
        end
    end

endmodule
